// File: rtl/adc_spi_capture.sv
// -----------------------------------------------------------------------------
// adc_spi_capture
//
// Front-end capture stage for an external CNV-style SPI ADC (3-wire read).
// A conversion is triggered by a single-cycle start request or runs
// back-to-back while enable is held. Each conversion holds adc_cnv high for
// CONV_CYCLES clocks. The block then drops adc_cs_n and clocks DATA_W bits
// in MSB first. The sample is presented on adc_data with a one-cycle
// adc_ready strobe.
//
// Parameters
//   DATA_W      sample width / shift length in bits (>= 2)
//   CLK_DIV     SCLK half-period in clk cycles (>= 1)
//   CONV_CYCLES clk cycles adc_cnv is held high per conversion (>= 1)
//
// Ports
//   clk, rst_n  system clock, asynchronous active-low reset
//   start       single-conversion request (only acted on in IDLE)
//   enable      continuous acquisition while high
//   clr_status  synchronous clear of overrun and sample_cnt
//   adc_sdo     serial data from ADC (changes after SCLK falling edge)
//   adc_cnv     conversion trigger to ADC
//   adc_cs_n    read chip select, active-low
//   adc_sclk    serial clock, idle low
//   adc_data    last captured sample, held until the next capture
//   adc_ready   one-cycle strobe: adc_data valid/updated
//   busy        high in any state except IDLE
//   overrun     sticky: start seen while busy
//   sample_cnt  completed captures, wraps 0xFFFF -> 0x0000
// -----------------------------------------------------------------------------
module adc_spi_capture #(
  parameter int DATA_W      = 16,
  parameter int CLK_DIV     = 4,
  parameter int CONV_CYCLES = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              enable,
  input  logic              clr_status,
  input  logic              adc_sdo,
  output logic              adc_cnv,
  output logic              adc_cs_n,
  output logic              adc_sclk,
  output logic [DATA_W-1:0] adc_data,
  output logic              adc_ready,
  output logic              busy,
  output logic              overrun,
  output logic [15:0]       sample_cnt
);

  localparam int CNV_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam int PH_W  = $clog2(2 * CLK_DIV);
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNV_W-1:0] CNV_LAST = CNV_W'(CONV_CYCLES - 1);
  // Phase at which SCLK is about to rise: the shift happens on that edge.
  localparam logic [PH_W-1:0]  PH_RISE  = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_HIGH  = PH_W'(CLK_DIV);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_SHIFT   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNV_W-1:0]   conv_cnt_q, conv_cnt_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [15:0]        sample_cnt_q, sample_cnt_d;
  logic               overrun_q, overrun_d;
  logic               cnv_q, cnv_d;
  logic               cs_n_q, cs_n_d;
  logic               sclk_q, sclk_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_s;

  // Next-state, datapath and registered-output next values.
  always_comb begin
    state_d      = state_q;
    conv_cnt_d   = conv_cnt_q;
    phase_d      = phase_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    data_d       = data_q;
    sample_cnt_d = sample_cnt_q;
    overrun_d    = overrun_q;

    case (state_q)
      S_IDLE: begin
        if (start || enable) begin
          state_d    = S_CONVERT;
          conv_cnt_d = '0;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_CONVERT: begin
        if (conv_cnt_q == CNV_LAST) begin
          state_d   = S_SHIFT;
          phase_d   = '0;
          bit_cnt_d = '0;
        end else begin
          conv_cnt_d = conv_cnt_q + CNV_W'(1);
        end
      end
      S_SHIFT: begin
        // adc_sdo is sampled on the same edge that raises adc_sclk, so the
        // value taken is the one the ADC drove after the previous fall.
        if (phase_q == PH_RISE) begin
          shift_d = {shift_q[DATA_W-2:0], adc_sdo};
        end else begin
          shift_d = shift_q;
        end
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = S_DONE;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Data and counter update on the edge entering DONE, so they are
    // already valid while adc_ready is high.
    done_s = (state_q == S_SHIFT) && (state_d == S_DONE);
    if (done_s) begin
      data_d = shift_q;
    end else begin
      data_d = data_q;
    end

    // clr_status dominates both the capture increment and a new overrun.
    if (clr_status) begin
      sample_cnt_d = 16'h0000;
      overrun_d    = 1'b0;
    end else begin
      if (done_s) begin
        sample_cnt_d = sample_cnt_q + 16'h0001;
      end else begin
        sample_cnt_d = sample_cnt_q;
      end
      if (start && (state_q != S_IDLE)) begin
        overrun_d = 1'b1;
      end else begin
        overrun_d = overrun_q;
      end
    end

    // Outputs are registered from the next state so they line up with it.
    cnv_d   = (state_d == S_CONVERT);
    cs_n_d  = (state_d != S_SHIFT);
    sclk_d  = (state_d == S_SHIFT) && (phase_d >= PH_HIGH);
    ready_d = (state_d == S_DONE);
    busy_d  = (state_d != S_IDLE);
  end

  // State, counters, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      conv_cnt_q   <= '0;
      phase_q      <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      sample_cnt_q <= 16'h0000;
      overrun_q    <= 1'b0;
      cnv_q        <= 1'b0;
      cs_n_q       <= 1'b1;
      sclk_q       <= 1'b0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      conv_cnt_q   <= conv_cnt_d;
      phase_q      <= phase_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      sample_cnt_q <= sample_cnt_d;
      overrun_q    <= overrun_d;
      cnv_q        <= cnv_d;
      cs_n_q       <= cs_n_d;
      sclk_q       <= sclk_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
    end
  end

  assign adc_cnv    = cnv_q;
  assign adc_cs_n   = cs_n_q;
  assign adc_sclk   = sclk_q;
  assign adc_data   = data_q;
  assign adc_ready  = ready_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;
  assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_adc_spi_capture.sv
// -----------------------------------------------------------------------------
// tb_adc_spi_capture
//
// Bench for adc_spi_capture (DATA_W=16, CLK_DIV=2, CONV_CYCLES=4).
// A behavioural ADC drives adc_sdo MSB first from a word queue. Every word
// handed to the ADC is also pushed to an expected queue. The monitor pops
// that queue on each adc_ready strobe and compares it with adc_data.
// -----------------------------------------------------------------------------
module tb_adc_spi_capture;

  localparam int DATA_W      = 16;
  localparam int CLK_DIV     = 2;
  localparam int CONV_CYCLES = 4;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              enable;
  logic              clr_status;
  logic              adc_sdo;
  logic              adc_cnv;
  logic              adc_cs_n;
  logic              adc_sclk;
  logic [DATA_W-1:0] adc_data;
  logic              adc_ready;
  logic              busy;
  logic              overrun;
  logic [15:0]       sample_cnt;

  adc_spi_capture #(
    .DATA_W     (DATA_W),
    .CLK_DIV    (CLK_DIV),
    .CONV_CYCLES(CONV_CYCLES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .enable    (enable),
    .clr_status(clr_status),
    .adc_sdo   (adc_sdo),
    .adc_cnv   (adc_cnv),
    .adc_cs_n  (adc_cs_n),
    .adc_sclk  (adc_sclk),
    .adc_data  (adc_data),
    .adc_ready (adc_ready),
    .busy      (busy),
    .overrun   (overrun),
    .sample_cnt(sample_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Comparison helper: counts every comparison, reports mismatches.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard queues.
  logic [15:0] adc_q[$];
  logic [15:0] exp_q[$];

  task automatic push_sample(input logic [15:0] w);
    adc_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // ADC model: new word when cs_n falls, next bit after each SCLK fall.
  logic [15:0] cur_word = 16'h0000;
  int          bit_idx  = 15;
  bit          cs_active = 1'b0;
  always begin
    @(adc_cs_n or negedge adc_sclk);
    if (adc_cs_n) begin
      cs_active = 1'b0;
    end else if (!cs_active) begin
      cs_active = 1'b1;
      cur_word  = (adc_q.size() > 0) ? adc_q.pop_front() : 16'h0000;
      bit_idx   = 15;
    end else if (bit_idx > 0) begin
      bit_idx--;
    end
    adc_sdo = cur_word[bit_idx];
  end

  // Monitor, sampled 1 time unit after each rising edge.
  int cyc = 0;
  int cnv_hi = 0, cnv_rises = 0, sclk_hi = 0, sclk_rises = 0;
  int ready_hi = 0, ready_cnt = 0, last_ready_cyc = 0;
  logic cnv_prev = 1'b0, sclk_prev = 1'b0, ready_prev = 1'b0;
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (adc_cnv) cnv_hi++;
    if (adc_cnv && !cnv_prev) cnv_rises++;
    if (adc_sclk) sclk_hi++;
    if (adc_sclk && !sclk_prev) sclk_rises++;
    if (adc_ready) ready_hi++;
    if (adc_ready && !ready_prev) begin
      ready_cnt++;
      last_ready_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 32'd1, 32'd0);
      end else begin
        check("sb_data", {16'h0000, adc_data}, {16'h0000, exp_q.pop_front()});
      end
    end
    cnv_prev   = adc_cnv;
    sclk_prev  = adc_sclk;
    ready_prev = adc_ready;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle start pulse; returns the cycle count at which start went high.
  task automatic pulse_start(output int c0);
    @(negedge clk);
    start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
  endtask

  task automatic wait_ready(input int budget, input string tag);
    int base;
    base = ready_cnt;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ready_cnt != base) break;
    end
    if (ready_cnt == base) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  int c0, r1, r2, r3;
  int s_cnv_hi, s_cnv_rises, s_sclk_hi, s_sclk_rises, s_ready_hi, s_ready_cnt;

  task automatic snap();
    s_cnv_hi     = cnv_hi;
    s_cnv_rises  = cnv_rises;
    s_sclk_hi    = sclk_hi;
    s_sclk_rises = sclk_rises;
    s_ready_hi   = ready_hi;
    s_ready_cnt  = ready_cnt;
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    enable     = 1'b0;
    clr_status = 1'b0;
    cycles(3);
    rst_n = 1'b1;

    // Reset and idle.
    cycles(20);
    check("rst_cnv",   {31'd0, adc_cnv},   32'd0);
    check("rst_cs_n",  {31'd0, adc_cs_n},  32'd1);
    check("rst_sclk",  {31'd0, adc_sclk},  32'd0);
    check("rst_data",  {16'd0, adc_data},  32'd0);
    check("rst_ready", ready_hi,           32'd0);
    check("rst_busy",  {31'd0, busy},      32'd0);
    check("rst_ovr",   {31'd0, overrun},   32'd0);
    check("rst_cnt",   {16'd0, sample_cnt}, 32'd0);

    // Single shot.
    snap();
    push_sample(16'hA5C3);
    pulse_start(c0);
    wait_ready(200, "t2");
    cycles(3);
    check("t2_latency",  last_ready_cyc - c0,       32'd69);
    check("t2_cnv_hi",   cnv_hi - s_cnv_hi,         32'd4);
    check("t2_cnv_rise", cnv_rises - s_cnv_rises,   32'd1);
    check("t2_sclk_n",   sclk_rises - s_sclk_rises, 32'd16);
    check("t2_sclk_hi",  sclk_hi - s_sclk_hi,       32'd32);
    check("t2_ready_hi", ready_hi - s_ready_hi,     32'd1);
    check("t2_data",     {16'd0, adc_data},         32'h0000A5C3);
    check("t2_cnt",      {16'd0, sample_cnt},       32'd1);
    check("t2_idle",     {30'd0, busy, adc_cs_n},   32'd1);

    // Continuous acquisition, enable dropped during the third conversion.
    pulse_clr();
    check("t3_clr_cnt", {16'd0, sample_cnt}, 32'd0);
    snap();
    push_sample(16'h5555);
    push_sample(16'hAAAA);
    push_sample(16'h0001);
    @(negedge clk);
    enable = 1'b1;
    c0 = cyc;
    wait_ready(200, "t3a");
    r1 = last_ready_cyc;
    wait_ready(200, "t3b");
    r2 = last_ready_cyc;
    cycles(3);
    enable = 1'b0;
    wait_ready(200, "t3c");
    r3 = last_ready_cyc;
    cycles(100);
    check("t3_first",    r1 - c0,                   32'd69);
    check("t3_period1",  r2 - r1,                   32'd70);
    check("t3_period2",  r3 - r2,                   32'd70);
    check("t3_cnt",      {16'd0, sample_cnt},       32'd3);
    check("t3_cnv_rise", cnv_rises - s_cnv_rises,   32'd3);
    check("t3_ready_n",  ready_cnt - s_ready_cnt,   32'd3);
    check("t3_busy",     {31'd0, busy},             32'd0);

    // Start while busy: overrun, no extra conversion.
    snap();
    push_sample(16'h0F0F);
    pulse_start(c0);
    cycles(20);
    check("t4_pre_ovr", {31'd0, overrun}, 32'd0);
    check("t4_in_shift", {31'd0, adc_cs_n}, 32'd0);
    pulse_start(r1);
    wait_ready(200, "t4");
    cycles(30);
    check("t4_ovr",       {31'd0, overrun},        32'd1);
    check("t4_cnv_rise",  cnv_rises - s_cnv_rises, 32'd1);
    check("t4_ready_n",   ready_cnt - s_ready_cnt, 32'd1);
    pulse_clr();
    check("t4_clr_ovr", {31'd0, overrun},     32'd0);
    check("t4_clr_cnt", {16'd0, sample_cnt},  32'd0);

    // Counter wrap, with start and enable together for one cycle.
    @(negedge clk);
    force dut.sample_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.sample_cnt_q;
    cycles(2);
    check("t5_preload", {16'd0, sample_cnt}, 32'h0000FFFF);
    snap();
    push_sample(16'h1234);
    @(negedge clk);
    start  = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    enable = 1'b0;
    wait_ready(200, "t5");
    cycles(20);
    check("t5_wrap",      {16'd0, sample_cnt},     32'd0);
    check("t5_no_ovr",    {31'd0, overrun},        32'd0);
    check("t5_cnv_rise",  cnv_rises - s_cnv_rises, 32'd1);

    // clr_status across the capture edge and the DONE cycle.
    snap();
    push_sample(16'hBEEF);
    pulse_start(c0);
    cycles(67);
    clr_status = 1'b1;
    cycles(2);
    clr_status = 1'b0;
    cycles(2);
    check("t5_clr_ready", ready_cnt - s_ready_cnt, 32'd1);
    check("t5_clr_cnt",   {16'd0, sample_cnt},     32'd0);
    check("t5_clr_data",  {16'd0, adc_data},       32'h0000BEEF);

    // Asynchronous reset in the middle of bit 8.
    push_sample(16'h1111);
    pulse_start(c0);
    cycles(37);
    check("t6_in_shift", {31'd0, adc_cs_n}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("t6_cs_n",  {31'd0, adc_cs_n},    32'd1);
    check("t6_sclk",  {31'd0, adc_sclk},    32'd0);
    check("t6_busy",  {31'd0, busy},        32'd0);
    check("t6_cnv",   {31'd0, adc_cnv},     32'd0);
    check("t6_data",  {16'd0, adc_data},    32'd0);
    check("t6_ready", {31'd0, adc_ready},   32'd0);
    exp_q.delete();
    adc_q.delete();
    cycles(2);
    rst_n = 1'b1;
    push_sample(16'h6C39);
    pulse_start(c0);
    wait_ready(200, "t6");
    cycles(2);
    check("t6_latency", last_ready_cyc - c0,   32'd69);
    check("t6_data2",   {16'd0, adc_data},     32'h00006C39);
    check("t6_cnt",     {16'd0, sample_cnt},   32'd1);
    check("t6_sb_empty", exp_q.size(),         32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
